// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the bus datapath: fetch with memory wait,
// decode, register-register ALU, MUL/DIV, NEG/NOT and HALT, plus sticky status.
module control_sequencer #(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16,
  parameter int CNT_BITS  = 16,
  parameter int WAIT_MAX  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 mem_ready,
  input  logic [BITS-1:0]      IRVal,
  output logic [REGISTERS-1:0] GPRin,
  output logic [REGISTERS-1:0] GPRout,
  output logic                 PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, Read,
  output logic                 MDRout, HILOout, RZout, PCout, INPUTout, BAout, OUTPUTin,
  output logic                 ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR,
  output logic                 NEGATE, NOT, IncPC,
  output logic [3:0]           tstate,
  output logic [CNT_BITS-1:0]  instr_count,
  output logic                 halted,
  output logic [1:0]           fault
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB = 5'b00100, OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110, OP_ROR = 5'b00111, OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001, OP_OR  = 5'b01010, OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111, OP_NEG = 5'b10000, OP_NOT = 5'b10001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
    S_T3   = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_STOP = 4'd7
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                halted_q, halted_d;
  logic [1:0]          fault_q, fault_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_bin, is_un, is_md, is_halt, regs_ok, legal;
  logic       unused_ir;

  assign op        = IRVal[31:27];
  assign ra        = IRVal[26:23];
  assign rb        = IRVal[22:19];
  assign rc        = IRVal[18:15];
  assign unused_ir = ^IRVal;

  function automatic logic [REGISTERS-1:0] onehot(input logic [3:0] idx);
    onehot = REGISTERS'(1) << idx;
  endfunction

  always_comb begin
    is_bin = 1'b0;
    is_un  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_MUL, OP_DIV: is_bin = 1'b1;
      OP_NEG, OP_NOT:                is_un  = 1'b1;
      default: ;
    endcase
  end

  // Only the register fields an opcode actually uses are range-checked.
  assign is_halt = (op == OP_HALT);
  assign is_md   = (op == OP_MUL) || (op == OP_DIV);
  assign regs_ok = (int'(rb) < REGISTERS) &&
                   (is_un || (int'(rc) < REGISTERS)) &&
                   (is_md || (int'(ra) < REGISTERS));
  assign legal   = (is_bin || is_un) && regs_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    GPRin    = '0;
    GPRout   = '0;
    {PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, Read} = '0;
    {MDRout, HILOout, RZout, PCout, INPUTout, BAout, OUTPUTin} = '0;
    {ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC} = '0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        RZin    = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        // PC+1 waits in RZ and is committed only on the cycle the read completes.
        if (mem_ready) begin
          RZout   = 1'b1;
          PCin    = 1'b1;
          wait_d  = '0;
          state_d = S_T2;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
            fault_d = 2'b10;
            state_d = S_STOP;
          end
        end
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_halt) begin
          halted_d = 1'b1;
          cnt_d    = cnt_q + CNT_BITS'(1);
          state_d  = S_STOP;
        end else if (!legal) begin
          fault_d = 2'b01;
          state_d = S_STOP;
        end else begin
          GPRout  = onehot(rb);
          RYin    = 1'b1;
          state_d = S_T4;
        end
      end
      S_T4: begin
        if (!is_un) GPRout = onehot(rc);
        RZin = 1'b1;
        case (op)
          OP_ADD: ADD    = 1'b1;
          OP_SUB: SUB    = 1'b1;
          OP_SHR: SHR    = 1'b1;
          OP_SHL: SHL    = 1'b1;
          OP_ROR: ROR    = 1'b1;
          OP_ROL: ROL    = 1'b1;
          OP_AND: AND    = 1'b1;
          OP_OR:  OR     = 1'b1;
          OP_MUL: MUL    = 1'b1;
          OP_DIV: DIV    = 1'b1;
          OP_NEG: NEGATE = 1'b1;
          OP_NOT: NOT    = 1'b1;
          default: ;
        endcase
        state_d = S_T5;
      end
      S_T5: begin
        if (is_md) begin
          HILOin = 1'b1;
        end else begin
          RZout = 1'b1;
          GPRin = onehot(ra);
        end
        cnt_d   = cnt_q + CNT_BITS'(1);
        state_d = run ? S_T0 : S_IDLE;
      end
      S_STOP: ;
      default: state_d = S_IDLE;
    endcase
  end

  assign tstate      = state_q;
  assign instr_count = cnt_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the bus datapath.
- Replaces hand-sequenced bench control with a synthesizable T-state machine: fetch, wait for memory, decode IR, execute register-register ALU, MUL/DIV, NEG/NOT and HALT.
- Drives every datapath control input.
- Parametrised in register count, word width and memory-wait timeout.

Parameters:
BITS, 32, datapath word width (IR width)
REGISTERS, 16, GPR count; GPRin/GPRout one-hot width
CNT_BITS, 16, width of retired-instruction counter
WAIT_MAX, 15, max T1 wait cycles before timeout fault

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
mem_ready  in  1  memory read data valid on MDataIn this cycle
IRVal  in  BITS  current IR contents from datapath
GPRin  out  REGISTERS  one-hot register write enables
GPRout  out  REGISTERS  one-hot register bus drives
PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, Read  out  1 each  latch/read enables
MDRout, HILOout, RZout, PCout, INPUTout, BAout, OUTPUTin  out  1 each  bus drives/enables (INPUTout, BAout, OUTPUTin held 0)
ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC  out  1 each  ALU op select (one-hot, at most one high)
tstate  out  4  current state code
instr_count  out  CNT_BITS  retired instructions
halted  out  1  sticky: HALT executed
fault  out  2  sticky: 00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- IR fields:
  - op = IRVal[31:27]
  - ra = [26:23]
  - rb = [22:19]
  - rc = [18:15]
  - register index ≥ REGISTERS is an illegal-opcode fault.
- Opcodes:
  - ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000
  - AND 01001, OR 01010, MUL 01110, DIV 01111, NEG 10000, NOT 10001, HALT 11011
  - all others illegal.
- States (tstate):
  - IDLE 0, T0 1, T1 2, T2 3, T3 4, T4 5, T5 6, STOP 7.
- Reset (sync): state=IDLE, all outputs 0, instr_count=0, halted=0, fault=00, wait counter=0. Reset mid-instruction aborts immediately.
- Output timing: control outputs are combinational from state, decoded op and mem_ready. They are valid the whole cycle and latched by the datapath on the next rising edge.
- IDLE: all controls 0. Go to T0 when run=1.
- T0: PCout, MARin, IncPC, RZin. Next state T1.
- T1: Read=1 and MDRin=1 every cycle.
  - mem_ready=0: stay in T1 and increment the wait counter. If the counter reaches WAIT_MAX, set fault=10 and go to STOP.
  - mem_ready=1: also assert RZout and PCin (exactly one PC update per fetch), clear the wait counter, go to T2.
- T2: MDRout, IRin. Next state T3.
- T3 decode (IRVal now holds the new instruction):
  - HALT: set halted, go to STOP (instruction counted).
  - illegal: set fault=01, go to STOP (not counted).
  - otherwise: GPRout[rb], RYin, go to T4.
- T4:
  - binary ops: GPRout[rc], matching op strobe, RZin.
  - NEG/NOT: op strobe and RZin only, GPRout=0.
  - Next state T5.
- T5 (last cycle):
  - ALU ops: RZout, GPRin[ra].
  - MUL/DIV: HILOin only (no GPRin, no RZout).
  - Increment instr_count (wraps modulo 2^CNT_BITS).
  - Next state T0 if run=1, else IDLE.
- run=0 mid-instruction: the instruction completes, then IDLE.
- STOP: all controls 0. Exited only by reset; run is ignored.
- Never drive two bus sources in one cycle. At most one bit of GPRin/GPRout is high.

Test Plan:
- Reset, then run=1, mem_ready=1, IRVal=0x4A920000 (AND R5,R2,R4) with datapath preloaded R2=13, R4=4 → T4: AND=1, GPRout=0x0010. T5: GPRin=0x0020, R5=4, instr_count=1.
- ADD same registers (IR=0x1A920000) → R5=17. Back-to-back second ADD with run held → R5 updated again 6 cycles later, instr_count=2.
- mem_ready low 3 cycles in T1 → state stays 2 for 4 cycles, Read/MDRin high throughout, PCin pulses exactly once. With mem_ready held 0 → after WAIT_MAX=15 cycles, fault=10, tstate=7.
- MUL (IR=0x71120000) → T5 has HILOin=1, GPRin=0. NOT (IR=0x89100000) → T4 GPRout=0.
- Illegal op 11111 → fault=01, tstate=7, instr_count unchanged. HALT → halted=1. run=0 then has no effect; reset clears both.
- Sync reset asserted in T4 → next edge: all outputs 0, state IDLE. Reset pulse shorter than the clock edge window has no effect.
